// File: rtl/qoi_pkg.sv
// Shared QOI constants: file framing bytes, chunk op codes and packer state type.
package qoi_pkg;

  localparam logic [31:0] QOI_MAGIC      = 32'h716F6966;  // "qoif"
  localparam int          QOI_HDR_BYTES  = 14;
  localparam int          QOI_END_BYTES  = 8;
  localparam logic [63:0] QOI_END_MARKER = 64'h0000_0000_0000_0001;

  // Chunk op codes emitted by the upstream encoder.
  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
  localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BODY,
    TRAILER,
    FLUSH
  } state_e;

endpackage

// File: rtl/qoi_byte_packer_if.sv
// Chunk-in / word-out streaming bus of the QOI byte packer.
interface qoi_byte_packer_if;

  logic [39:0] sink_data;
  logic [2:0]  sink_len;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [31:0] source_data;
  logic [1:0]  source_empty;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic [31:0] frame_len;
  logic        frame_done;

  // Environment side: drives chunks and the downstream ready.
  modport master (
    output sink_data, sink_len, sink_valid, sink_sop, sink_eop, source_ready,
    input  sink_ready, source_data, source_empty, source_valid, source_sop,
    input  source_eop, frame_len, frame_done
  );

  // Packer side.
  modport slave (
    input  sink_data, sink_len, sink_valid, sink_sop, sink_eop, source_ready,
    output sink_ready, source_data, source_empty, source_valid, source_sop,
    output source_eop, frame_len, frame_done
  );

endinterface

// File: rtl/qoi_byte_acc.sv
// 8-byte FIFO-ordered accumulator: push 0..5 bytes, pop the oldest 4.
// Oldest byte lives at acc_q[63:56].
module qoi_byte_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  push_n,
  input  logic [39:0] push_data,
  input  logic        pop,
  output logic [3:0]  cnt,
  output logic [3:0]  cnt_eff,
  output logic [31:0] word
);

  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] shifted;
  logic [63:0] keep_mask;
  logic [39:0] push_mask;

  // Occupancy after this cycle's pop; a short final word pops everything.
  always_comb begin
    cnt_eff = cnt_q;
    if (pop) cnt_eff = (cnt_q >= 4'd4) ? cnt_q - 4'd4 : 4'd0;
  end

  // Shift out the popped word, keep live bytes, append pushed bytes behind them.
  always_comb begin
    shifted   = pop ? {acc_q[31:0], 32'h0} : acc_q;
    keep_mask = ~({64{1'b1}} >> {cnt_eff, 3'b000});
    push_mask = ~({40{1'b1}} >> {push_n, 3'b000});
    acc_d     = (shifted & keep_mask) | ({push_data & push_mask, 24'h0} >> {cnt_eff, 3'b000});
    cnt_d     = cnt_eff + {1'b0, push_n};
  end

  // Occupancy count is control state and is cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  // Byte storage needs no reset: bytes beyond cnt are always masked.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign cnt  = cnt_q;
  assign word = acc_q[63:32] & ~(32'hFFFF_FFFF >> {cnt_q, 3'b000});

endmodule

// File: rtl/qoi_byte_packer.sv
// Wraps the QOI chunk stream into a complete .qoi file on a 32-bit byte stream:
// header, chunk payload, end marker, plus per-file byte length.
module qoi_byte_packer
  import qoi_pkg::*;
#(
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int CHANNELS   = 3,
  parameter int COLORSPACE = 0
) (
  input logic             clk,
  input logic             reset_n,  // active-high despite the name
  qoi_byte_packer_if.slave bus
);

  localparam logic [111:0] HDR_SEQ = {QOI_MAGIC, 32'(IMAGE_W), 32'(IMAGE_H),
                                      8'(CHANNELS), 8'(COLORSPACE)};
  // Zero tail lets a 4-byte window slide all the way to the last header byte.
  localparam logic [143:0] HDR_PAD = {HDR_SEQ, 32'h0};

  state_e      state_q, state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [3:0]  trl_idx_q, trl_idx_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] frame_len_q, frame_len_d;
  logic        frame_done_q, frame_done_d;
  logic        sop_q, sop_d;

  logic [2:0]  push_n;
  logic [39:0] push_data;
  logic [3:0]  cnt, cnt_eff;
  logic [31:0] word;
  logic        src_valid, pop, room, eop, sink_ready, start;
  logic [3:0]  hdr_left;
  logic [31:0] hdr_word, end_word;

  qoi_byte_acc u_acc (
    .clk      (clk),
    .rst      (reset_n),
    .push_n   (push_n),
    .push_data(push_data),
    .pop      (pop),
    .cnt      (cnt),
    .cnt_eff  (cnt_eff),
    .word     (word)
  );

  assign src_valid = (cnt >= 4'd4) || (state_q == FLUSH && cnt != 4'd0);
  assign pop       = src_valid && bus.source_ready;
  assign room      = cnt_eff <= 4'd3;
  assign eop       = state_q == FLUSH && src_valid && cnt <= 4'd4;
  assign start     = state_q == IDLE && bus.sink_valid && bus.sink_sop;
  assign hdr_left  = 4'(QOI_HDR_BYTES) - hdr_idx_q;
  assign hdr_word  = 32'((HDR_PAD << {hdr_idx_q, 3'b000}) >> 112);
  assign end_word  = (trl_idx_q == 4'd0) ? QOI_END_MARKER[63:32] : QOI_END_MARKER[31:0];

  // State and control registers.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= IDLE;
      hdr_idx_q    <= 4'd0;
      trl_idx_q    <= 4'd0;
      byte_cnt_q   <= 32'd0;
      frame_len_q  <= 32'd0;
      frame_done_q <= 1'b0;
      sop_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      trl_idx_q    <= trl_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      sop_q        <= sop_d;
    end
  end

  // Next-state: the final push of a section moves straight to the next section.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HEADER;
      HEADER:  if (room && hdr_left <= 4'd4) state_d = BODY;
      BODY:    if (room && bus.sink_valid && bus.sink_eop) state_d = TRAILER;
      TRAILER: if (room && trl_idx_q == 4'(QOI_END_BYTES - 4)) state_d = FLUSH;
      FLUSH:   if (pop && eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Push selection, input handshake and frame bookkeeping per state.
  always_comb begin
    push_n       = 3'd0;
    push_data    = 40'h0;
    sink_ready   = 1'b0;
    hdr_idx_d    = hdr_idx_q;
    trl_idx_d    = trl_idx_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    sop_d        = sop_q && !pop;
    case (state_q)
      IDLE: begin
        // Beats arriving before a sop are swallowed; the sop beat waits for BODY.
        sink_ready = bus.sink_valid && !bus.sink_sop;
        if (start) begin
          hdr_idx_d = 4'd0;
          trl_idx_d = 4'd0;
          sop_d     = 1'b1;
        end
      end
      HEADER: if (room) begin
        push_n    = (hdr_left > 4'd4) ? 3'd4 : hdr_left[2:0];
        push_data = {hdr_word, 8'h0};
        hdr_idx_d = hdr_idx_q + {1'b0, push_n};
      end
      BODY: begin
        sink_ready = room;
        if (room && bus.sink_valid) begin
          push_n    = (bus.sink_len > 3'd5) ? 3'd5 : bus.sink_len;
          push_data = bus.sink_data;
        end
      end
      TRAILER: if (room) begin
        push_n    = 3'd4;
        push_data = {end_word, 8'h0};
        trl_idx_d = trl_idx_q + 4'd4;
      end
      FLUSH: if (pop && eop) begin
        frame_done_d = 1'b1;
        frame_len_d  = byte_cnt_q;
      end
      default: ;
    endcase
    byte_cnt_d = start ? 32'd0 : byte_cnt_q + 32'(push_n);
  end

  assign bus.sink_ready   = sink_ready;
  assign bus.source_data  = word;
  assign bus.source_valid = src_valid;
  assign bus.source_sop   = sop_q && src_valid;
  assign bus.source_eop   = eop;
  assign bus.source_empty = eop ? 2'(4'd4 - cnt) : 2'd0;
  assign bus.frame_len    = frame_len_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: doc/qoi_byte_packer.md
Name: qoi_byte_packer

Overview:
- Sits directly downstream of the QOI chunk encoder: consumes its variable-length chunk stream (0-5 bytes per beat) and emits a gap-free, 32-bit-word Avalon-ST byte stream holding a complete .qoi file.
- Inserts the 14-byte QOI header at frame start and the 8-byte end marker at frame end.
- Reports the total byte length of each frame for the downstream DMA/SDRAM writer.

Parameters:
IMAGE_W, 640, header width field, 32-bit big-endian
IMAGE_H, 480, header height field, 32-bit big-endian
CHANNELS, 3, header channels byte
COLORSPACE, 0, header colorspace byte

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-high reset (asserted = 1)
sink_data  in  40  chunk bytes; byte0 at [39:32] … byte4 at [7:0]
sink_len  in  3  valid byte count of sink_data, 0..5; bytes are taken from byte0 upward
sink_valid  in  1  input beat valid
sink_ready  out  1  input beat accepted when sink_valid && sink_ready
sink_sop  in  1  first chunk of frame
sink_eop  in  1  last chunk of frame
source_data  out  32  output word; first byte at [31:24]
source_empty  out  2  unused low bytes in the final word (non-zero only with source_eop)
source_valid  out  1  output word valid
source_ready  in  1  downstream ready
source_sop  out  1  first word of file
source_eop  out  1  last word of file
frame_len  out  32  byte count of last completed file, including header and trailer
frame_done  out  1  one-cycle pulse when the eop word is accepted

Behaviour:
- Reset, asynchronous: state=IDLE, acc count=0, header index=0, trailer index=0. All outputs are 0: sink_ready=0, source_valid=0, frame_len=0, frame_done=0.
- Accumulator: 8-byte FIFO-ordered register acc plus cnt (4 bits, 0..8).
  - pop = source_valid && source_ready.
  - cnt_eff = cnt - (pop ? 4 : 0).
  - Per-cycle push is allowed only if cnt_eff <= 3.
  - cnt_next = cnt_eff + pushed bytes. Pop and push may occur in the same cycle.
- source_valid = (cnt >= 4) || (state==FLUSH && cnt > 0). source_data = the oldest 4 acc bytes, with unused bytes driven 0.
- States:
  - IDLE:
    - sink_ready=0.
    - On sink_valid && sink_sop, go to HEADER. The sop beat is not consumed here.
    - A sink_valid beat without sink_sop is consumed and dropped: sink_ready=1 for that beat only while no sop is present.
  - HEADER:
    - Push min(4, 14 - hdr_idx) bytes per allowed cycle from the fixed sequence "qoif", IMAGE_W[31:0], IMAGE_H[31:0], CHANNELS, COLORSPACE.
    - When hdr_idx reaches 14, go to BODY.
  - BODY:
    - sink_ready = (cnt_eff <= 3). Combinational on source_ready; this is permitted.
    - An accepted beat pushes sink_len bytes. sink_len=0 is accepted and pushes nothing. sink_len > 5 is clamped to 5.
    - An accepted beat with sink_eop goes to TRAILER.
    - sink_sop seen in BODY is treated as ordinary data.
  - TRAILER: push up to 4 bytes per allowed cycle of 00 00 00 00 00 00 00 01. After 8 bytes, go to FLUSH.
  - FLUSH:
    - Emit the remaining words.
    - The word with cnt <= 4 at pop carries source_eop=1 and source_empty = 4 - cnt.
    - On its acceptance: pulse frame_done, latch frame_len, go to IDLE with cnt=0.
- source_sop = 1 on the first header word only. It is held until that word is accepted.
- Byte counter: 32-bit, cleared on entering HEADER, incremented by every pushed byte. frame_len = counter value at eop acceptance.
- Output word and flags stay stable while source_valid && !source_ready.
- Reset asserted mid-frame aborts immediately. The next frame starts clean at IDLE with no stale bytes.

Decomposition:
- Package qoi_pkg: QOI_MAGIC = 32'h716F6966, QOI_HDR_BYTES = 14, QOI_END_BYTES = 8, the end-marker constant, the state enum type (IDLE, HEADER, BODY, TRAILER, FLUSH), and the chunk op codes shared with the encoder.
- One sub-module: qoi_byte_acc (8-byte accumulator with push-N/pop-4, cnt, and cnt_eff output). The FSM and header/trailer sequencing stay in qoi_byte_packer.

Test Plan:
- Minimal frame: IMAGE_W=640, IMAGE_H=480; one beat {len=1, byte0=C0, sop=1, eop=1}, source_ready=1.
  - Words: 716F6966 (sop), 00000280, 000001E0, 0300C000, 00000000, 00000100 (eop, empty=1).
  - frame_len = 23, single frame_done pulse.
- Mixed lengths: beats of len 4, 2, 0, 5, 1 (eop) with distinct bytes.
  - Output bytes are the exact concatenation in order.
  - frame_len = 14 + 12 + 8 = 34; last word empty = 2.
- Backpressure: random source_ready toggling on the mixed-length frame.
  - Byte sequence identical to the no-stall case; source_data/flags never change while stalled.
  - sink_ready never asserted when cnt_eff > 3.
- Exact-fit end: payload of 2 bytes so the total is 24.
  - Last word 00000001 with source_eop=1, empty=0; no extra word.
- Pre-sop garbage: three beats without sop while in IDLE, then a valid frame.
  - Garbage is consumed and never appears in the output; output starts with 716F6966.
- Reset mid-BODY: assert reset_n=1 for 1 cycle after 5 output words.
  - source_valid drops to 0 asynchronously.
  - The following frame's first word is 716F6966 with sop, and its frame_len is correct.
